// File: rtl/ifmap_distributor.sv
// Owns the PE pointer and ifG counter and bursts one ifmap group per request into one PE or all PEs.
// Reads in cycles 1..GROUP_LEN after ifwen, writes one cycle later, and load_done pulses at GROUP_LEN+2.
// Commands arriving mid-burst are dropped; with IFD_BUSY_ERR_EN defined they also set a sticky err flag.
module ifmap_distributor #(
    parameter int PE_COUNT  = 3,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int SP_AW     = 4,
    parameter int GROUP_LEN = 4,
    parameter int IFG_COUNT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rst_dp,
    input  logic                en_onehot,
    input  logic                cnt_ifG,
    input  logic                ifwen,
    input  logic                sel_addr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_ren,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [PE_COUNT-1:0] pe_wen,
    output logic [SP_AW-1:0]    pe_waddr,
    output logic [DATA_W-1:0]   pe_wdata,
    output logic [PE_COUNT-1:0] onehot,
    output logic                co_onehot,
    output logic                co_ifG,
`ifdef IFD_BUSY_ERR_EN
    output logic                err,
`endif
    output logic                load_busy,
    output logic                load_done
);
    localparam int IFG_W = (IFG_COUNT > 2) ? $clog2(IFG_COUNT) : 1;

    typedef enum logic [1:0] {IDLE, READ, LAST, DONE} state_t;

    state_t             state;
    logic [IFG_W-1:0]   ifg_cnt;
    logic [SP_AW-1:0]   k;
    logic               mode;
    logic [ADDR_W-1:0]  ptr_idx;
    logic [ADDR_W-1:0]  grp_base;
    logic [ADDR_W-1:0]  uni_base;
    logic               clear;

    assign clear     = rst | rst_dp;
    assign co_onehot = onehot[PE_COUNT-1];
    assign co_ifG    = (ifg_cnt == IFG_W'(IFG_COUNT - 1));
    // Write data is the memory return itself; zero whenever no PE is being written.
    assign pe_wdata  = (|pe_wen) ? mem_rdata : '0;

    always_comb begin
        ptr_idx = '0;
        for (int i = 0; i < PE_COUNT; i++) begin
            if (onehot[i]) ptr_idx = ADDR_W'(i);
        end
    end

    assign grp_base = ADDR_W'(ifg_cnt) * ADDR_W'(PE_COUNT * GROUP_LEN);
    assign uni_base = grp_base + ptr_idx * ADDR_W'(GROUP_LEN);

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= IDLE;
            onehot    <= PE_COUNT'(1);
            ifg_cnt   <= '0;
            k         <= '0;
            mode      <= 1'b0;
            mem_ren   <= 1'b0;
            mem_addr  <= '0;
            pe_wen    <= '0;
            pe_waddr  <= '0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_onehot)
                        onehot <= (onehot << 1) | (onehot >> (PE_COUNT - 1));
                    if (cnt_ifG)
                        ifg_cnt <= co_ifG ? '0 : ifg_cnt + 1'b1;
                    if (ifwen) begin
                        state     <= READ;
                        mode      <= sel_addr;
                        k         <= '0;
                        mem_ren   <= 1'b1;
                        mem_addr  <= sel_addr ? grp_base : uni_base;
                        load_busy <= 1'b1;
                    end
                end
                READ: begin
                    pe_wen   <= mode ? '1 : onehot;
                    pe_waddr <= k;
                    if (k == SP_AW'(GROUP_LEN - 1)) begin
                        state   <= LAST;
                        mem_ren <= 1'b0;
                    end else begin
                        k        <= k + 1'b1;
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
                LAST: begin
                    pe_wen    <= '0;
                    load_busy <= 1'b0;
                    load_done <= 1'b1;
                    state     <= DONE;
                end
                default: begin
                    load_done <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef IFD_BUSY_ERR_EN
    always_ff @(posedge clk) begin
        if (clear)
            err <= 1'b0;
        else if ((state != IDLE) && (ifwen | en_onehot | cnt_ifG))
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_ifmap_distributor.sv
// Directed bench for ifmap_distributor: reset, unicast/broadcast bursts, pointer/counter wrap, abort, busy drop.
module tb_ifmap_distributor;
    logic        clk = 1'b0;
    logic        rst = 1'b0, rst_dp = 1'b0, en_onehot = 1'b0, cnt_ifG = 1'b0;
    logic        ifwen = 1'b0, sel_addr = 1'b0;
    logic [9:0]  mem_addr;
    logic        mem_ren;
    logic [15:0] mem_rdata = '0;
    logic [2:0]  pe_wen;
    logic [3:0]  pe_waddr;
    logic [15:0] pe_wdata;
    logic [2:0]  onehot;
    logic        co_onehot, co_ifG, load_busy, load_done;
`ifdef IFD_BUSY_ERR_EN
    logic        err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Memory returns address + 100 one cycle after a read.
    always @(posedge clk) if (mem_ren) mem_rdata <= 16'(mem_addr) + 16'd100;

    ifmap_distributor dut (
        .clk(clk), .rst(rst), .rst_dp(rst_dp), .en_onehot(en_onehot), .cnt_ifG(cnt_ifG),
        .ifwen(ifwen), .sel_addr(sel_addr), .mem_addr(mem_addr), .mem_ren(mem_ren),
        .mem_rdata(mem_rdata), .pe_wen(pe_wen), .pe_waddr(pe_waddr), .pe_wdata(pe_wdata),
        .onehot(onehot), .co_onehot(co_onehot), .co_ifG(co_ifG),
`ifdef IFD_BUSY_ERR_EN
        .err(err),
`endif
        .load_busy(load_busy), .load_done(load_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        rst = 1'b1; step(); step(); rst = 1'b0;
        check("rst_onehot", 32'(onehot), 32'h1);
        check("rst_ifg", 32'(dut.ifg_cnt), 0);
        check("rst_co_onehot", 32'(co_onehot), 0);
        check("rst_co_ifG", 32'(co_ifG), 0);
        check("rst_busy", 32'(load_busy), 0);
        check("rst_pe_wen", 32'(pe_wen), 0);
        check("rst_wdata", 32'(pe_wdata), 0);

        // Unicast: pointer -> PE1, ifg = 2, base = 2*12 + 1*4 = 28
        en_onehot = 1'b1; step(); en_onehot = 1'b0;
        cnt_ifG = 1'b1; step(); step(); cnt_ifG = 1'b0;
        check("uni_onehot", 32'(onehot), 32'h2);
        ifwen = 1'b1; sel_addr = 1'b0; step(); ifwen = 1'b0;
        check("uni_c1_wen", 32'(pe_wen), 0);
        for (int c = 1; c <= 4; c++) begin
            check("uni_ren", 32'(mem_ren), 1);
            check("uni_addr", 32'(mem_addr), 32'(27 + c));
            check("uni_busy", 32'(load_busy), 1);
            if (c > 1) begin
                check("uni_wen", 32'(pe_wen), 32'h2);
                check("uni_waddr", 32'(pe_waddr), 32'(c - 2));
                check("uni_wdata", 32'(pe_wdata), 32'(126 + c));
            end
            step();
        end
        check("uni_c5_ren", 32'(mem_ren), 0);
        check("uni_c5_wen", 32'(pe_wen), 32'h2);
        check("uni_c5_waddr", 32'(pe_waddr), 3);
        check("uni_c5_wdata", 32'(pe_wdata), 131);
        check("uni_c5_busy", 32'(load_busy), 1);
        check("uni_c5_done", 32'(load_done), 0);
        step();
        check("uni_c6_done", 32'(load_done), 1);
        check("uni_c6_wen", 32'(pe_wen), 0);
        check("uni_c6_busy", 32'(load_busy), 0);
        step();
        check("uni_c7_done", 32'(load_done), 0);

        // Broadcast: ifg = 2, base = 24
        ifwen = 1'b1; sel_addr = 1'b1; step(); ifwen = 1'b0; sel_addr = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c <= 4) check("bc_addr", 32'(mem_addr), 32'(23 + c));
            if (c > 1) begin
                check("bc_wen", 32'(pe_wen), 32'h7);
                check("bc_wdata", 32'(pe_wdata), 32'(122 + c));
            end
            step();
        end
        check("bc_done", 32'(load_done), 1);
        check("bc_wen_off", 32'(pe_wen), 0);
        step();

        // Wrap of pointer and counter
        rst_dp = 1'b1; step(); rst_dp = 1'b0;
        check("wr_clr_onehot", 32'(onehot), 32'h1);
        en_onehot = 1'b1; step(); step(); en_onehot = 1'b0;
        check("wr_onehot_100", 32'(onehot), 32'h4);
        check("wr_co_onehot", 32'(co_onehot), 1);
        en_onehot = 1'b1; step(); en_onehot = 1'b0;
        check("wr_onehot_001", 32'(onehot), 32'h1);
        check("wr_co_onehot0", 32'(co_onehot), 0);
        cnt_ifG = 1'b1;
        for (int i = 0; i < 7; i++) step();
        cnt_ifG = 1'b0;
        check("wr_co_ifG", 32'(co_ifG), 1);
        check("wr_ifg7", 32'(dut.ifg_cnt), 7);
        cnt_ifG = 1'b1; step(); cnt_ifG = 1'b0;
        check("wr_ifg0", 32'(dut.ifg_cnt), 0);
        check("wr_co_ifG0", 32'(co_ifG), 0);
        en_onehot = 1'b1; cnt_ifG = 1'b1; step(); en_onehot = 1'b0; cnt_ifG = 1'b0;
        check("both_onehot", 32'(onehot), 32'h2);
        check("both_ifg", 32'(dut.ifg_cnt), 1);

        // Abort: ifg=1, PE1 -> base 16; rst_dp during cycle 3
        ifwen = 1'b1; step(); ifwen = 1'b0;
        check("ab_addr", 32'(mem_addr), 16);
        step(); step();
        check("ab_c3_wen", 32'(pe_wen), 32'h2);
        rst_dp = 1'b1; step(); rst_dp = 1'b0;
        check("ab_wen", 32'(pe_wen), 0);
        check("ab_ren", 32'(mem_ren), 0);
        check("ab_busy", 32'(load_busy), 0);
        check("ab_onehot", 32'(onehot), 32'h1);
        check("ab_ifg", 32'(dut.ifg_cnt), 0);
        for (int i = 0; i < 4; i++) begin
            check("ab_no_done", 32'(load_done), 0);
            check("ab_no_wen", 32'(pe_wen), 0);
            step();
        end

        // Busy protection: en_onehot + ifwen during READ are dropped
        ifwen = 1'b1; step();
        en_onehot = 1'b1; step(); ifwen = 1'b0; en_onehot = 1'b0;
        check("bz_onehot", 32'(onehot), 32'h1);
`ifdef IFD_BUSY_ERR_EN
        check("bz_err", 32'(err), 1);
`endif
        step(); step(); step(); step();
        check("bz_done", 32'(load_done), 1);
        step();
        check("bz_no_second_ren", 32'(mem_ren), 0);
        check("bz_idle", 32'(load_busy), 0);
        check("bz_onehot_end", 32'(onehot), 32'h1);
`ifdef IFD_BUSY_ERR_EN
        check("bz_err_sticky", 32'(err), 1);
        rst_dp = 1'b1; step(); rst_dp = 1'b0;
        check("bz_err_clr", 32'(err), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
